// File: rtl/mcycle_unit.sv
// Multi-cycle multiply/divide unit.
// Iterative 32-step shift-add multiplier and restoring divider.
// Optional feature macro: MCYCLE_SIGNED_EN. When it is defined, Signed=1
// selects two's-complement operation. When it is undefined, the Signed
// input is ignored and every operation is unsigned.
module mcycle_unit (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        Start,
  input  logic        MCycleOp,
  input  logic        Signed,
  input  logic [31:0] Operand1,
  input  logic [31:0] Operand2,
  output logic [31:0] Result1,
  output logic [31:0] Result2,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t      state;
  logic [4:0]  count;
  logic        op_div;
  logic [63:0] acc;       // product accumulator, or partial remainder in [32:0]
  logic [63:0] mcand;     // shifted multiplicand, or divisor in [31:0]
  logic [31:0] shreg;     // multiplier shifting out, or dividend shifting into quotient
  logic [31:0] dvd_orig;  // original dividend, returned as remainder on divide by zero
  logic        div_zero;
  logic        neg_lo;    // negate product / quotient at the end
  logic        neg_hi;    // negate remainder at the end

  // Two's-complement conditional negation, used for magnitudes and sign fix-up
  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

  logic sgn_req;
`ifdef MCYCLE_SIGNED_EN
  assign sgn_req = Signed;
`else
  logic unused_signed;
  assign sgn_req       = 1'b0;
  assign unused_signed = Signed;
`endif

  logic        op1_neg, op2_neg;
  logic [31:0] op1_mag, op2_mag;
  assign op1_neg = sgn_req & Operand1[31];
  assign op2_neg = sgn_req & Operand2[31];
  assign op1_mag = cond_neg32(Operand1, op1_neg);
  assign op2_mag = cond_neg32(Operand2, op2_neg);

  // One iteration of each algorithm. The divider is restoring: it keeps
  // the shifted remainder whenever the trial subtraction goes negative.
  logic [63:0] mul_acc_nxt;
  logic [32:0] rem_shift, trial, rem_nxt;
  logic        q_bit;
  assign mul_acc_nxt = shreg[0] ? (acc + mcand) : acc;
  assign rem_shift   = {acc[31:0], shreg[31]};
  assign trial       = rem_shift - {1'b0, mcand[31:0]};
  assign q_bit       = ~trial[32];
  assign rem_nxt     = q_bit ? trial : rem_shift;

  // Final-step results with sign correction; divide by zero is forced
  // so it matches the unsigned behaviour irrespective of signedness.
  logic [63:0] prod_fin;
  logic [31:0] quot_fin, rem_fin, res_lo, res_hi;
  assign prod_fin = cond_neg64(mul_acc_nxt, neg_lo);
  assign quot_fin = cond_neg32({shreg[30:0], q_bit}, neg_lo);
  assign rem_fin  = cond_neg32(rem_nxt[31:0], neg_hi);

  // Select the result pair that is loaded on entry into DONE
  always_comb begin
    res_lo = prod_fin[31:0];
    res_hi = prod_fin[63:32];
    if (op_div) begin
      if (div_zero) begin
        res_lo = 32'hFFFF_FFFF;
        res_hi = dvd_orig;
      end else begin
        res_lo = quot_fin;
        res_hi = rem_fin;
      end
    end
  end

  // Control FSM, iteration datapath and registered outputs
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state    <= IDLE;
      count    <= 5'd0;
      op_div   <= 1'b0;
      acc      <= 64'd0;
      mcand    <= 64'd0;
      shreg    <= 32'd0;
      dvd_orig <= 32'd0;
      div_zero <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      Result1  <= 32'd0;
      Result2  <= 32'd0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      Busy <= (state == COMPUTE);
      Done <= (state == DONE);
      case (state)
        IDLE: begin
          if (Start) begin
            op_div   <= MCycleOp;
            acc      <= 64'd0;
            mcand    <= {32'd0, MCycleOp ? op2_mag : op1_mag};
            shreg    <= MCycleOp ? op1_mag : op2_mag;
            dvd_orig <= Operand1;
            div_zero <= (Operand2 == 32'd0);
            neg_lo   <= op1_neg ^ op2_neg;
            neg_hi   <= op1_neg;
            count    <= 5'd0;
            state    <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (op_div) begin
            acc   <= {31'd0, rem_nxt};
            shreg <= {shreg[30:0], q_bit};
          end else begin
            acc   <= mul_acc_nxt;
            mcand <= mcand << 1;
            shreg <= shreg >> 1;
          end
          count <= count + 5'd1;
          if (count == 5'd31) begin
            Result1 <= res_lo;
            Result2 <= res_hi;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_unit.sv
// Scoreboard bench for mcycle_unit: the driver queues expected results,
// and a monitor checks them whenever Done is presented.
module tb_mcycle_unit;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic        Start;
  logic        MCycleOp;
  logic        Signed;
  logic [31:0] Operand1;
  logic [31:0] Operand2;
  logic [31:0] Result1;
  logic [31:0] Result2;
  logic        Busy;
  logic        Done;

  mcycle_unit dut (
    .CLK(CLK), .RESETN(RESETN), .Start(Start), .MCycleOp(MCycleOp),
    .Signed(Signed), .Operand1(Operand1), .Operand2(Operand2),
    .Result1(Result1), .Result2(Result2), .Busy(Busy), .Done(Done)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: every Done pulse must match the oldest queued expectation
  always @(negedge CLK) begin
    if (RESETN && Done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result1", {32'd0, Result1}, {32'd0, e.r1});
        check("result2", {32'd0, Result2}, {32'd0, e.r2});
        check("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Issue one operation; optionally re-assert Start with other operands mid-run
  task automatic run_op(input logic op, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e1,
                        input logic [31:0] e2, input bit poke);
    exp_t e;
    int   busy_n;
    bit   got;
    @(negedge CLK);
    Operand1 = a; Operand2 = b; MCycleOp = op; Signed = sgn; Start = 1'b1;
    e.r1 = e1; e.r2 = e2; e.cyc = cyc + 1 + 33;
    sb.push_back(e);
    @(negedge CLK);
    Start = 1'b0;
    busy_n = 0;
    got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (Done) begin
        got = 1'b1;
        break;
      end
      if (Busy) busy_n++;
      if (poke && k == 5) begin
        Start = 1'b1; Operand1 = 32'h0000_DEAD; Operand2 = 32'd3; MCycleOp = ~op;
      end
      if (poke && k == 9) Start = 1'b0;
      @(negedge CLK);
    end
    check("done_seen", {63'd0, got}, 64'd1);
    check("busy_cycles", 64'(busy_n), 64'd32);
    @(negedge CLK);
    check("done_single_pulse", {63'd0, Done}, 64'd0);
    check("result1_hold", {32'd0, Result1}, {32'd0, e1});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RESETN = 1'b0; Start = 1'b0; MCycleOp = 1'b0; Signed = 1'b0;
    Operand1 = 32'd0; Operand2 = 32'd0;
    repeat (3) @(negedge CLK);
    check("rst_busy", {63'd0, Busy}, 64'd0);
    check("rst_done", {63'd0, Done}, 64'd0);
    check("rst_result1", {32'd0, Result1}, 64'd0);
    check("rst_result2", {32'd0, Result2}, 64'd0);
    RESETN = 1'b1;

    run_op(1'b0, 1'b0, 32'd7, 32'd6, 32'd42, 32'd0, 1'b0);
    run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    run_op(1'b0, 1'b0, 32'h1234_5678, 32'h10, 32'h2345_6780, 32'h0000_0001, 1'b0);
    run_op(1'b1, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run_op(1'b1, 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b0);
    // Start re-asserted mid-run must not disturb 100 / 7
    run_op(1'b1, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b1);
    // Divide by zero with Signed=1 returns the raw dividend in both builds
    run_op(1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0);
`ifdef MCYCLE_SIGNED_EN
    run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFF4, 32'hFFFF_FFFF, 1'b0);
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
`else
    // Signed is ignored: the same bit patterns are treated as unsigned
    run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0);
    run_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFF4, 32'd3, 1'b0);
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
`endif

    // Reset 10 cycles into COMPUTE: outputs clear at once, op is discarded
    @(negedge CLK);
    Operand1 = 32'd1000; Operand2 = 32'd1000; MCycleOp = 1'b0; Signed = 1'b0; Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    repeat (10) @(negedge CLK);
    #2 RESETN = 1'b0;
    #1;
    check("midrst_busy", {63'd0, Busy}, 64'd0);
    check("midrst_done", {63'd0, Done}, 64'd0);
    check("midrst_result1", {32'd0, Result1}, 64'd0);
    check("midrst_result2", {32'd0, Result2}, 64'd0);
    @(negedge CLK);
    RESETN = 1'b1;
    run_op(1'b0, 1'b0, 32'd3, 32'd3, 32'd9, 32'd0, 1'b0);

    repeat (3) @(negedge CLK);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
